// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port block RAM with a built-in clear sequencer.
// Port A is the CPU read/write port. Port B is a read-only video/sprite port.
// A small FSM fills every word with CLEAR_VALUE after reset (optional) or when
// clr_req is pulsed, one word per clock. The FSM owns the array while busy.
module ram_dp_clr #(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_wren,
  output logic [DATA_WIDTH-1:0] a_q,
  input  logic [ADDR_WIDTH-1:0] b_address,
  output logic [DATA_WIDTH-1:0] b_q,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic   RESET_BUSY  = (CLEAR_ON_RESET != 0);

  // Storage
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Sequencer state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;

  // Read registers
  logic [DATA_WIDTH-1:0] r_a_q;
  logic [DATA_WIDTH-1:0] r_b_q;

  // Single write port into the array, shared by clear sequencer and port A
  logic                  w_a_write;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // Port A may only write in IDLE on an edge that is not starting a clear.
  assign w_a_write = (r_state == ST_IDLE) && a_wren && !clr_req;

  // Next-state logic for the clear sequencer
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_busy_nxt     = r_busy;
    unique case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
          w_busy_nxt     = 1'b1;
        end
      end
      ST_CLEAR: begin
        // Terminal compare ends the pass before the address wraps back to 0.
        w_clr_addr_nxt = r_clr_addr + 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset restarts any clear at address 0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RESET_STATE;
      r_clr_addr <= '0;
      r_busy     <= RESET_BUSY;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Write-port arbitration: clear owns the array, reset blocks every write
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = a_address;
    w_mem_wdata = a_data;
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_clr_addr;
        w_mem_wdata = CLEAR_VALUE;
      end else if (w_a_write) begin
        w_mem_we = 1'b1;
      end
    end
  end

  // Array write; kept free of reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Registered reads; non-blocking array access yields the old word on collisions
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_a_q <= CLEAR_VALUE;
      r_b_q <= CLEAR_VALUE;
    end else begin
      if (w_a_write && (RDW_MODE == 0)) begin
        r_a_q <= a_data;
      end else begin
        r_a_q <= r_mem[a_address];
      end
      r_b_q <= r_mem[b_address];
    end
  end

  assign a_q  = r_a_q;
  assign b_q  = r_b_q;
  assign busy = r_busy;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed self-checking bench for ram_dp_clr (AW=4, DW=8, CLEAR_VALUE=A5).
// u0: write-first with clear on reset; u1: read-first; u2: no clear on reset.
module tb_ram_dp_clr;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] CV = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic          rst0, clr0, aw0, busy0;
  logic [AW-1:0] aa0, ba0;
  logic [DW-1:0] ad0, aq0, bq0;

  logic          rst1, clr1, aw1, busy1;
  logic [AW-1:0] aa1, ba1;
  logic [DW-1:0] ad1, aq1, bq1;

  logic          rst2, clr2, aw2, busy2;
  logic [AW-1:0] aa2, ba2;
  logic [DW-1:0] ad2, aq2, bq2;

  ram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u0 (
    .clock(clk), .reset(rst0), .a_address(aa0), .a_data(ad0), .a_wren(aw0),
    .a_q(aq0), .b_address(ba0), .b_q(bq0), .clr_req(clr0), .busy(busy0));

  ram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u1 (
    .clock(clk), .reset(rst1), .a_address(aa1), .a_data(ad1), .a_wren(aw1),
    .a_q(aq1), .b_address(ba1), .b_q(bq1), .clr_req(clr1), .busy(busy1));

  ram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0),
               .CLEAR_ON_RESET(0), .CLEAR_VALUE(CV)) u2 (
    .clock(clk), .reset(rst2), .a_address(aa2), .a_data(ad2), .a_wren(aw2),
    .a_q(aq2), .b_address(ba2), .b_q(bq2), .clr_req(clr2), .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b1; clr0 = 1'b0; aw0 = 1'b0; aa0 = '0; ba0 = '0; ad0 = '0;
    rst1 = 1'b1; clr1 = 1'b0; aw1 = 1'b0; aa1 = '0; ba1 = '0; ad1 = '0;
    rst2 = 1'b1; clr2 = 1'b0; aw2 = 1'b0; aa2 = '0; ba2 = '0; ad2 = '0;

    // 1. reset 3 cycles, clear runs for 16 cycles, all words read A5
    repeat (3) tick();
    check("rst_aq0", aq0, 8'h00);
    check("rst_bq0", bq0, 8'h00);
    check("rst_busy0", {7'b0, busy0}, 8'h01);
    check("rst_busy1", {7'b0, busy1}, 8'h01);
    check("rst_busy2", {7'b0, busy2}, 8'h00);
    check("rst_aq2", aq2, 8'h00);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    check("rel_busy0", {7'b0, busy0}, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("clr_busy0_%0d", k), {7'b0, busy0}, (k < 16) ? 8'h01 : 8'h00);
      check($sformatf("clr_busy1_%0d", k), {7'b0, busy1}, (k < 16) ? 8'h01 : 8'h00);
      if (k == 1) check("clr_aq0", aq0, CV);
    end
    for (int i = 0; i < 16; i++) begin
      aa0 = 4'(i); ba0 = 4'(15 - i);
      tick();
      check($sformatf("fill_aq0_%0d", i), aq0, CV);
      check($sformatf("fill_bq0_%0d", 15 - i), bq0, CV);
    end

    // 2. write-first write of 3C to addr 5, port B sees it one cycle later
    aa0 = 4'd5; ad0 = 8'h3C; aw0 = 1'b1; ba0 = 4'd5;
    tick();
    check("wf_aq0", aq0, 8'h3C);
    check("wf_bq0_old", bq0, CV);
    aw0 = 1'b0;
    tick();
    check("wf_bq0_new", bq0, 8'h3C);
    check("wf_aq0_rd", aq0, 8'h3C);

    // 4. same-address collision at addr 2
    aa0 = 4'd2; ad0 = 8'h99; aw0 = 1'b1; ba0 = 4'd2;
    tick();
    check("col_bq0_old", bq0, CV);
    aw0 = 1'b0;
    tick();
    check("col_bq0_new", bq0, 8'h99);

    // 3. read-first on u1 at addr 7
    aa1 = 4'd7; ad1 = 8'h11; aw1 = 1'b1;
    tick();
    check("rf_aq1_first", aq1, CV);
    ad1 = 8'h22;
    tick();
    check("rf_aq1_old", aq1, 8'h11);
    aw1 = 1'b0;
    tick();
    check("rf_aq1_new", aq1, 8'h22);

    // 5. clr_req, reset 6 cycles in, writes during busy are lost
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("req_busy0", {7'b0, busy0}, 8'h01);
    aa0 = 4'd3; ad0 = 8'h77; aw0 = 1'b1;
    repeat (5) tick();
    check("mid_busy0", {7'b0, busy0}, 8'h01);
    check("mid_aq0", aq0, CV);
    rst0 = 1'b1;
    tick();
    check("mrst_busy0", {7'b0, busy0}, 8'h01);
    check("mrst_aq0", aq0, 8'h00);
    rst0 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("rclr_busy0_%0d", k), {7'b0, busy0}, (k < 16) ? 8'h01 : 8'h00);
    end
    aw0 = 1'b0;
    aa0 = 4'd3; ba0 = 4'd5;
    tick();
    check("lost_aq0_a3", aq0, CV);
    check("rclr_bq0_a5", bq0, CV);
    aa0 = 4'd2; ba0 = 4'd3;
    tick();
    check("rclr_aq0_a2", aq0, CV);
    check("lost_bq0_a3", bq0, CV);

    // 6. no clear on reset: contents survive a reset pulse
    aa2 = 4'd9; ad2 = 8'h5A; aw2 = 1'b1;
    tick();
    check("ncr_aq2_wr", aq2, 8'h5A);
    aw2 = 1'b0; rst2 = 1'b1;
    tick();
    check("ncr_busy2_rst", {7'b0, busy2}, 8'h00);
    check("ncr_aq2_rst", aq2, 8'h00);
    check("ncr_bq2_rst", bq2, 8'h00);
    rst2 = 1'b0; ba2 = 4'd9;
    tick();
    check("ncr_aq2_keep", aq2, 8'h5A);
    check("ncr_bq2_keep", bq2, 8'h5A);
    check("ncr_busy2", {7'b0, busy2}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
